// File: rtl/muldiv_seq_ctrl.sv
// EXE-stage hi/lo sequencer: latches operands for the multiplier/divider IP, counts its latency,
// captures the 64-bit result and holds it until accepted. Optional build macro: DIV_ZERO_SKIP_EN.
module muldiv_seq_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 30,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic        op_signed,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   input  logic        ready,
   output logic [31:0] ip_a,
   output logic [31:0] ip_b,
   output logic        ip_signed,
   input  logic [63:0] mul_p,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   // state  | meaning
   // S_IDLE | no op in flight, waiting for start
   // S_MUL  | multiply in flight, counting MUL_LAT
   // S_DIV  | divide in flight, counting DIV_LAT
   // S_DONE | hi_out/lo_out valid, waiting for ready
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;

   logic w_start;
   logic w_can_launch;
   logic w_launch;
   logic w_div_zero;

   assign w_start      = start_mult | start_div;
   assign w_can_launch = (r_state == S_IDLE) || ((r_state == S_DONE) && ready);
   assign w_launch     = w_can_launch && w_start;

`ifdef DIV_ZERO_SKIP_EN
   assign w_div_zero = start_div && (rt_val == 32'd0);
`else
   assign w_div_zero = 1'b0;
`endif

   // flush outranks launch; a DONE state with ready and start relaunches without an idle bubble
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ip_a      <= '0;
         ip_b      <= '0;
         ip_signed <= 1'b0;
         hi_out    <= '0;
         lo_out    <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (w_launch) begin
         ip_a      <= rs_val;
         ip_b      <= rt_val;
         ip_signed <= op_signed;
         if (w_div_zero) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            hi_out  <= rs_val;
            lo_out  <= 32'hFFFF_FFFF;
         end else if (start_div) begin
            r_state <= S_DIV;
            r_cnt   <= DIV_CNT_INIT;
            busy    <= 1'b1;
            done    <= 1'b0;
         end else begin
            r_state <= S_MUL;
            r_cnt   <= MUL_CNT_INIT;
            busy    <= 1'b1;
            done    <= 1'b0;
         end
      end else begin
         case (r_state)
            S_MUL, S_DIV: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  if (r_state == S_MUL) begin
                     hi_out <= mul_p[63:32];
                     lo_out <= mul_p[31:0];
                  end else begin
                     hi_out <= div_r;
                     lo_out <= div_q;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (ready) begin
                  r_state <= S_IDLE;
                  done    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: pipelined IP stand-ins plus an arithmetic reference
// model; scenario tasks check latency, result, hold, flush, back-to-back and priority behaviour.
module tb_muldiv_seq_ctrl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 30;
   localparam int CNT_W   = 6;
`ifdef DIV_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        start_mult, start_div, op_signed, flush, ready;
   logic [31:0] rs_val, rt_val;
   logic [31:0] ip_a, ip_b;
   logic        ip_signed;
   logic [63:0] mul_p;
   logic [31:0] div_q, div_r;
   logic        busy, done;
   logic [31:0] hi_out, lo_out;

   int checks = 0;
   int errors = 0;

   muldiv_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .start_mult(start_mult), .start_div(start_div),
      .op_signed(op_signed), .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .ready(ready),
      .ip_a(ip_a), .ip_b(ip_b), .ip_signed(ip_signed), .mul_p(mul_p), .div_q(div_q),
      .div_r(div_r), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   // reference arithmetic: {hi,lo} for multiply, {remainder,quotient} for divide
   function automatic logic [63:0] ref_result(input bit is_div, input bit sg,
                                              input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] q, r, res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         if (sg) res = sa * sb;
         else    res = {32'd0, a} * {32'd0, b};
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else if (sg) begin
         q   = sa / sb;
         r   = sa % sb;
         res = {r[31:0], q[31:0]};
      end else begin
         res = {a % b, a / b};
      end
      return res;
   endfunction

   function automatic int ref_lat(input bit is_div, input logic [31:0] b);
      if (is_div && b == 32'd0 && SKIP) return 0;
      return is_div ? DIV_LAT : MUL_LAT;
   endfunction

   // pipelined IP stand-ins: a result appears exactly LAT cycles after its operands
   logic [63:0] mpipe [MUL_LAT-1];
   logic [63:0] dpipe [DIV_LAT-1];
   always @(posedge clk) begin
      mpipe[0] <= ref_result(1'b0, ip_signed, ip_a, ip_b);
      dpipe[0] <= ref_result(1'b1, ip_signed, ip_a, ip_b);
      for (int i = 1; i < MUL_LAT - 1; i++) mpipe[i] <= mpipe[i-1];
      for (int j = 1; j < DIV_LAT - 1; j++) dpipe[j] <= dpipe[j-1];
   end
   assign mul_p = mpipe[MUL_LAT-2];
   assign div_r = dpipe[DIV_LAT-2][63:32];
   assign div_q = dpipe[DIV_LAT-2][31:0];

   // drive a one-cycle start at a negedge; returns at the next negedge with operands scrambled
   task automatic launch(input bit sm, input bit sd, input bit sg,
                         input logic [31:0] a, input logic [31:0] b);
      start_mult = sm; start_div = sd; op_signed = sg; rs_val = a; rt_val = b;
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0; op_signed = $urandom;
      rs_val = $urandom; rt_val = $urandom;
   endtask

   // count consecutive busy cycles from the current negedge (bounded)
   task automatic measure(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({busy, done, ip_signed} !== 3'b000 || ip_a !== 32'd0 || ip_b !== 32'd0 ||
          hi_out !== 32'd0 || lo_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: busy=%b done=%b sg=%b a=%h b=%h hi=%h lo=%h want all 0",
                  busy, done, ip_signed, ip_a, ip_b, hi_out, lo_out);
      end
   endtask

   task automatic test_multu_basic;
      int n;
      ready = 1'b1;
      launch(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
      measure(n);
      checks++;
      if (n !== MUL_LAT) begin errors++; $display("FAIL multu_busy: got %0d want %0d", n, MUL_LAT); end
      checks++;
      if (done !== 1'b1 || hi_out !== 32'h1 || lo_out !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL multu_result: done=%b hi=%h lo=%h want 1 00000001 fffffffe", done, hi_out, lo_out);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL multu_done_width: done=%b busy=%b want 0 0", done, busy);
      end
      checks++;
      if (ip_a !== 32'hFFFF_FFFF || ip_b !== 32'd2 || ip_signed !== 1'b0) begin
         errors++; $display("FAIL multu_ip_hold: a=%h b=%h sg=%b want ffffffff 2 0", ip_a, ip_b, ip_signed);
      end
   endtask

   task automatic test_div_signed;
      int n;
      launch(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
      measure(n);
      checks++;
      if (n !== DIV_LAT) begin errors++; $display("FAIL div_busy: got %0d want %0d", n, DIV_LAT); end
      checks++;
      if (done !== 1'b1 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL div_result: done=%b hi=%h lo=%h want 1 ffffffff fffffffd", done, hi_out, lo_out);
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      int n;
      bit is_div, sg;
      logic [31:0] a, b;
      logic [63:0] exp;
      ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         is_div = $urandom;
         sg     = $urandom;
         a      = $urandom;
         b      = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         exp    = ref_result(is_div, sg, a, b);
         launch(!is_div, is_div, sg, a, b);
         measure(n);
         checks++;
         if (n !== ref_lat(is_div, b)) begin
            errors++; $display("FAIL rand_busy[%0d]: got %0d want %0d", k, n, ref_lat(is_div, b));
         end
         checks++;
         if (done !== 1'b1 || {hi_out, lo_out} !== exp) begin
            errors++;
            $display("FAIL rand_result[%0d]: done=%b hilo=%h want %h", k, done, {hi_out, lo_out}, exp);
         end
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_ready_hold;
      int n;
      logic [31:0] a, b;
      logic [63:0] exp;
      a = $urandom; b = $urandom;
      exp = ref_result(1'b0, 1'b1, a, b);
      ready = 1'b0;
      launch(1'b1, 1'b0, 1'b1, a, b);
      measure(n);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || {hi_out, lo_out} !== exp) begin
            errors++;
            $display("FAIL hold_done[%0d]: done=%b busy=%b hilo=%h want 1 0 %h",
                     i, done, busy, {hi_out, lo_out}, exp);
         end
         start_mult = (i == 2);
         rs_val     = ~a;
         @(negedge clk);
      end
      start_mult = 1'b0;
      checks++;
      if (ip_a !== a || ip_b !== b) begin
         errors++; $display("FAIL hold_start_ignored: a=%h b=%h want %h %h", ip_a, ip_b, a, b);
      end
      ready = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL hold_release: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_flush;
      int n;
      bit seen;
      logic [31:0] a, b, da;
      logic [63:0] prev, exp2;
      a = $urandom; b = $urandom;
      prev = ref_result(1'b0, 1'b0, a, b);
      ready = 1'b1;
      launch(1'b1, 1'b0, 1'b0, a, b);
      measure(n);
      @(negedge clk);
      // flush at busy cycle 10 of a divide
      da = $urandom;
      launch(1'b0, 1'b1, 1'b0, da, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL flush_div_drop: busy=%b done=%b want 0 0", busy, done);
      end
      seen = 1'b0;
      repeat (DIV_LAT + 5) begin
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0 || {hi_out, lo_out} !== prev) begin
         errors++;
         $display("FAIL flush_div_keep: activity=%b hilo=%h want 0 %h", seen, {hi_out, lo_out}, prev);
      end
      // flush in the same cycle as start
      flush = 1'b1;
      launch(1'b1, 1'b0, 1'b0, ~da, 32'd7);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ip_a !== da) begin
         errors++; $display("FAIL flush_beats_start: busy=%b done=%b a=%h want 0 0 %h", busy, done, ip_a, da);
      end
      // flush on the final (counter==0) cycle of a multiply
      launch(1'b1, 1'b0, 1'b0, $urandom, $urandom);
      repeat (MUL_LAT - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {hi_out, lo_out} !== prev) begin
         errors++;
         $display("FAIL flush_last_cycle: busy=%b done=%b hilo=%h want 0 0 %h", busy, done, {hi_out, lo_out}, prev);
      end
      // flush while waiting in DONE
      a = $urandom; b = $urandom;
      exp2 = ref_result(1'b0, 1'b1, a, b);
      ready = 1'b0;
      launch(1'b1, 1'b0, 1'b1, a, b);
      measure(n);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      ready = 1'b1;
      checks++;
      if (done !== 1'b0 || {hi_out, lo_out} !== exp2) begin
         errors++; $display("FAIL flush_in_done: done=%b hilo=%h want 0 %h", done, {hi_out, lo_out}, exp2);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      logic [31:0] a, b;
      logic [63:0] exp;
      ready = 1'b1;
      launch(1'b1, 1'b0, 1'b0, $urandom, $urandom);
      measure(n);
      a = $urandom; b = $urandom;
      exp = ref_result(1'b0, 1'b1, a, b);
      launch(1'b1, 1'b0, 1'b1, a, b);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || ip_a !== a) begin
         errors++; $display("FAIL b2b_no_bubble: busy=%b done=%b a=%h want 1 0 %h", busy, done, ip_a, a);
      end
      measure(n);
      checks++;
      if (n !== MUL_LAT || {hi_out, lo_out} !== exp) begin
         errors++; $display("FAIL b2b_result: busy=%0d hilo=%h want %0d %h", n, {hi_out, lo_out}, MUL_LAT, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_both_start;
      int n;
      logic [31:0] a, b;
      logic [63:0] exp;
      a = $urandom; b = 32'($urandom_range(1, 1000));
      exp = ref_result(1'b1, 1'b0, a, b);
      launch(1'b1, 1'b1, 1'b0, a, b);
      measure(n);
      checks++;
      if (n !== DIV_LAT || {hi_out, lo_out} !== exp) begin
         errors++; $display("FAIL both_start_div: busy=%0d hilo=%h want %0d %h", n, {hi_out, lo_out}, DIV_LAT, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy;
      int n;
      logic [31:0] a, b;
      logic [63:0] exp;
      a = $urandom; b = $urandom;
      exp = ref_result(1'b0, 1'b0, a, b);
      launch(1'b1, 1'b0, 1'b0, a, b);
      @(negedge clk);
      start_div = 1'b1; rs_val = ~a; rt_val = 32'd5;
      @(negedge clk);
      start_div = 1'b0;
      measure(n);
      checks++;
      if (n !== MUL_LAT - 2 || {hi_out, lo_out} !== exp || ip_a !== a) begin
         errors++;
         $display("FAIL busy_start_ignored: rem=%0d hilo=%h a=%h want %0d %h %h",
                  n, {hi_out, lo_out}, ip_a, MUL_LAT - 2, exp, a);
      end
      @(negedge clk);
   endtask

   task automatic test_div_zero;
      int n;
      launch(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
      measure(n);
      checks++;
      if (n !== ref_lat(1'b1, 32'd0) || done !== 1'b1 || hi_out !== 32'd5 || lo_out !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_zero: busy=%0d done=%b hi=%h lo=%h want %0d 1 00000005 ffffffff",
                  n, done, hi_out, lo_out, ref_lat(1'b1, 32'd0));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      bit seen;
      launch(1'b0, 1'b1, 1'b1, $urandom, 32'd9);
      repeat (5) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({busy, done, ip_signed} !== 3'b000 || ip_a !== 32'd0 || ip_b !== 32'd0 ||
          hi_out !== 32'd0 || lo_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_op: busy=%b done=%b sg=%b a=%h b=%h hi=%h lo=%h want all 0",
                  busy, done, ip_signed, ip_a, ip_b, hi_out, lo_out);
      end
      @(negedge clk);
      resetn = 1'b1;
      seen = 1'b0;
      repeat (DIV_LAT + 5) begin
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_quiet: activity=%b want 0", seen); end
   endtask

   initial begin
      resetn = 1'b0; start_mult = 1'b0; start_div = 1'b0; op_signed = 1'b0;
      rs_val = '0; rt_val = '0; flush = 1'b0; ready = 1'b1;
      repeat (3) @(negedge clk);
      test_reset;
      resetn = 1'b1;
      @(negedge clk);
      test_multu_basic;
      test_div_signed;
      test_random;
      test_ready_hold;
      test_flush;
      test_back_to_back;
      test_both_start;
      test_start_while_busy;
      test_div_zero;
      test_reset_mid_op;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
